// File: rtl/rf_dump_reader_if.sv
// Output stream of the register-file dump engine: one (address, data)
// beat per valid/ready handshake. The dump engine is the master and the
// debug consumer is the slave.
interface rf_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();

    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        output dump_ready
    );

endinterface

// File: rtl/rf_dump_reader.sv
// Debug read-out engine for the integer register file.
//
// On start the engine walks the register file through one read port and
// streams every register out as an (address, data) beat. Each register
// takes an ADDR cycle (read address stable, value captured at the end of
// the cycle) followed by at least one SEND cycle (beat presented until the
// consumer accepts it), so a full walk costs two cycles per register with
// the consumer always ready.
//
// The register file's read port is combinational and returns the value
// from before any write landing in the same cycle, so the write port is
// snooped during the capture cycle and a matching write is forwarded into
// the beat. x0 is hard-wired to zero in the register file, so writes aimed
// at it are never forwarded.
module rf_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SKIP_X0  = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    input  logic              abort,

    output logic [ADDR_W-1:0] rg_rd_addr,
    input  logic [DATA_W-1:0] rg_rd_data,

    input  logic              rg_wrt_en,
    input  logic [ADDR_W-1:0] rg_wrt_dest,
    input  logic [DATA_W-1:0] rg_wrt_data,

    rf_dump_reader_if.master  dump,

    output logic              busy,
    output logic              done
);

    // First register visited: x1 when x0 is skipped, otherwise x0.
    localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

    // Last register visited; the walk stops here and never wraps.
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;

    logic              beat_valid;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              handshake;
    logic              at_last;

    // The read address is the walk index itself, so it is a register and
    // stays stable for the whole ADDR cycle.
    assign rg_rd_addr      = idx;

    assign dump.dump_valid = beat_valid;
    assign dump.dump_addr  = beat_addr;
    assign dump.dump_data  = beat_data;

    // Pick the value to capture: a same-cycle write to the register being
    // read wins over the stale read-port value, except for x0.
    always_comb begin
        fwd_hit   = rg_wrt_en && (rg_wrt_dest == idx) && (idx != '0);
        fwd_data  = fwd_hit ? rg_wrt_data : rg_rd_data;
        handshake = beat_valid && dump.dump_ready;
        at_last   = (idx == LAST_IDX);
    end

    // Walk sequencer: all outputs are registered here, including the
    // one-cycle done pulse that marks the FIN state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            beat_valid <= 1'b0;
            beat_addr  <= '0;
            beat_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx   <= FIRST_IDX;
                        busy  <= 1'b1;
                        state <= ADDR;
                    end
                end

                ADDR: begin
                    if (abort) begin
                        beat_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        beat_data  <= fwd_data;
                        beat_addr  <= idx;
                        beat_valid <= 1'b1;
                        state      <= SEND;
                    end
                end

                SEND: begin
                    if (abort) begin
                        beat_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (handshake) begin
                        beat_valid <= 1'b0;
                        if (at_last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ADDR;
                        end
                    end
                end

                FIN: begin
                    beat_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    beat_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader. Instance a walks from x1, instance b
// walks from x0. Both read a behavioural register file whose read port is
// combinational and whose write lands at the clock edge.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, abort;
    logic        wrt_en;
    logic [4:0]  wrt_dest;
    logic [31:0] wrt_data;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [31:0] regs [32];

    int tests_run = 0;
    int failed    = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
    rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    rf_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .rg_rd_addr(rd_addr_a), .rg_rd_data(rd_data_a),
        .rg_wrt_en(wrt_en), .rg_wrt_dest(wrt_dest), .rg_wrt_data(wrt_data),
        .dump(ifa), .busy(busy_a), .done(done_a)
    );

    rf_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .rg_rd_addr(rd_addr_b), .rg_rd_data(rd_data_b),
        .rg_wrt_en(wrt_en), .rg_wrt_dest(wrt_dest), .rg_wrt_data(wrt_data),
        .dump(ifb), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    // One clock edge; the register-file model commits any write at the edge.
    task tick();
        @(posedge clk);
        if (wrt_en && wrt_dest != 5'd0) regs[wrt_dest] <= wrt_data;
        #1;
    endtask

    // Advance until instance a presents a beat for register a (bounded).
    task wait_beat_a(input logic [4:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifa.dump_valid === 1'b1 && ifa.dump_addr === a) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Advance until instance a is in its capture cycle for register a.
    task wait_capture_a(input logic [4:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy_a === 1'b1 && ifa.dump_valid === 1'b0 && rd_addr_a === a) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task test_reset();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({rd_addr_a, ifa.dump_valid, ifa.dump_addr, ifa.dump_data, busy_a, done_a} !== '0) begin
            failed++;
            $display("[TB] FAIL reset_a: got addr=%h v=%b a=%h d=%h busy=%b done=%b want all 0",
                     rd_addr_a, ifa.dump_valid, ifa.dump_addr, ifa.dump_data, busy_a, done_a);
        end
        tests_run++;
        if ({rd_addr_b, ifb.dump_valid, ifb.dump_addr, ifb.dump_data, busy_b, done_b} !== '0) begin
            failed++;
            $display("[TB] FAIL reset_b: got addr=%h v=%b a=%h d=%h busy=%b done=%b want all 0",
                     rd_addr_b, ifb.dump_valid, ifb.dump_addr, ifb.dump_data, busy_b, done_b);
        end
        rst = 1'b1;
        tick();
    endtask

    task test_basic_dump();
        int          beats, order_err, first_cyc, done_cyc, dc0;
        logic        busy_after;
        logic [31:0] d4, d31;
        beats = 0; order_err = 0; first_cyc = -1; done_cyc = -1;
        busy_after = 1'b1; d4 = '0; d31 = '0;
        regs[4]  = 32'h1234_5678;
        regs[31] = 32'hDEAD_BEEF;
        dc0 = done_cnt_a;
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tests_run++;
        if (ifa.dump_valid !== 1'b0 || busy_a !== 1'b1) begin
            failed++;
            $display("[TB] FAIL basic_capture_cycle: got valid=%b busy=%b want valid=0 busy=1",
                     ifa.dump_valid, busy_a);
        end
        for (int c = 1; c <= 66; c++) begin
            tick();
            if (ifa.dump_valid === 1'b1) begin
                if (beats == 0) first_cyc = c;
                if (ifa.dump_addr !== 5'(beats + 1)) order_err++;
                if (ifa.dump_addr === 5'd4)  d4  = ifa.dump_data;
                if (ifa.dump_addr === 5'd31) d31 = ifa.dump_data;
                beats++;
            end
            if (done_a === 1'b1 && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy_a;
        end
        tests_run++;
        if (first_cyc != 1) begin
            failed++;
            $display("[TB] FAIL basic_first_valid: got cycle %0d want 1", first_cyc);
        end
        tests_run++;
        if (beats != 31 || order_err != 0) begin
            failed++;
            $display("[TB] FAIL basic_beats: got %0d beats, %0d out of order, want 31 and 0", beats, order_err);
        end
        tests_run++;
        if (d4 !== 32'h1234_5678) begin
            failed++;
            $display("[TB] FAIL basic_x4: got %h want 12345678", d4);
        end
        tests_run++;
        if (d31 !== 32'hDEAD_BEEF) begin
            failed++;
            $display("[TB] FAIL basic_x31: got %h want deadbeef", d31);
        end
        tests_run++;
        if (done_cyc != 62 || done_cnt_a - dc0 != 1) begin
            failed++;
            $display("[TB] FAIL basic_done: got cycle %0d count %0d want 62 and 1", done_cyc, done_cnt_a - dc0);
        end
        tests_run++;
        if (busy_after !== 1'b0) begin
            failed++;
            $display("[TB] FAIL basic_busy_after: got %b want 0", busy_after);
        end
    endtask

    task test_backpressure();
        bit ok;
        int hold_err;
        hold_err = 0;
        regs[7] = 32'hA5A5_A5A5;
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_beat_a(5'd7, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("[TB] FAIL bp_reach_7: got timeout want beat 7");
        end
        ifa.dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd7 || ifa.dump_data !== 32'hA5A5_A5A5)
                hold_err++;
            tick();
        end
        tests_run++;
        if (hold_err != 0) begin
            failed++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", hold_err);
        end
        ifa.dump_ready = 1'b1;
        tick();
        tests_run++;
        if (ifa.dump_valid !== 1'b0 || rd_addr_a !== 5'd8) begin
            failed++;
            $display("[TB] FAIL bp_after_hs: got valid=%b rd_addr=%0d want 0 and 8", ifa.dump_valid, rd_addr_a);
        end
        tick();
        tests_run++;
        if (ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd8) begin
            failed++;
            $display("[TB] FAIL bp_next_beat: got valid=%b addr=%0d want 1 and 8", ifa.dump_valid, ifa.dump_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task test_write_forward();
        bit ok;
        regs[5] = 32'h1111_1111;
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_capture_a(5'd5, ok);
        ifa.dump_ready = 1'b0;
        wrt_en = 1'b1; wrt_dest = 5'd5; wrt_data = 32'hCAFE_F00D;
        tick();
        wrt_en = 1'b0;
        tests_run++;
        if (!ok || ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd5 || ifa.dump_data !== 32'hCAFE_F00D) begin
            failed++;
            $display("[TB] FAIL fwd_capture: got found=%b valid=%b addr=%0d data=%h want 1 1 5 cafef00d",
                     ok, ifa.dump_valid, ifa.dump_addr, ifa.dump_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;

        regs[5] = 32'h1111_1111;
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_beat_a(5'd5, ok);
        ifa.dump_ready = 1'b0;
        wrt_en = 1'b1; wrt_dest = 5'd5; wrt_data = 32'hCAFE_F00D;
        tick();
        wrt_en = 1'b0;
        tests_run++;
        if (!ok || ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd5 || ifa.dump_data !== 32'h1111_1111) begin
            failed++;
            $display("[TB] FAIL fwd_late_write: got found=%b valid=%b addr=%0d data=%h want 1 1 5 11111111",
                     ok, ifa.dump_valid, ifa.dump_addr, ifa.dump_data);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task test_abort_restart();
        bit ok;
        int dc0;
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_beat_a(5'd10, ok);
        ifa.dump_ready = 1'b0;
        tick();
        dc0 = done_cnt_a;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests_run++;
        if (!ok || ifa.dump_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            failed++;
            $display("[TB] FAIL abort_stop: got found=%b valid=%b busy=%b done=%b want 1 0 0 0",
                     ok, ifa.dump_valid, busy_a, done_a);
        end
        tick();
        tests_run++;
        if (done_cnt_a != dc0) begin
            failed++;
            $display("[TB] FAIL abort_no_done: got %0d done pulses want 0", done_cnt_a - dc0);
        end
        ifa.dump_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tests_run++;
        if (ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd1) begin
            failed++;
            $display("[TB] FAIL abort_restart: got valid=%b addr=%0d want 1 and 1", ifa.dump_valid, ifa.dump_addr);
        end
    endtask

    task test_busy_start_and_reset();
        bit ok;
        int dc0;
        wait_beat_a(5'd12, ok);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tests_run++;
        if (!ok || ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd13) begin
            failed++;
            $display("[TB] FAIL busy_start_13: got found=%b valid=%b addr=%0d want 1 1 13", ok, ifa.dump_valid, ifa.dump_addr);
        end
        tick();
        tick();
        tests_run++;
        if (ifa.dump_valid !== 1'b1 || ifa.dump_addr !== 5'd14 || busy_a !== 1'b1) begin
            failed++;
            $display("[TB] FAIL busy_start_14: got valid=%b addr=%0d busy=%b want 1 14 1", ifa.dump_valid, ifa.dump_addr, busy_a);
        end
        wait_beat_a(5'd20, ok);
        dc0 = done_cnt_a;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests_run++;
        if (!ok || {rd_addr_a, ifa.dump_valid, ifa.dump_addr, ifa.dump_data, busy_a, done_a} !== '0) begin
            failed++;
            $display("[TB] FAIL mid_reset: got found=%b addr=%h v=%b a=%h d=%h busy=%b done=%b want 1 and all 0",
                     ok, rd_addr_a, ifa.dump_valid, ifa.dump_addr, ifa.dump_data, busy_a, done_a);
        end
        tick();
        tick();
        tests_run++;
        if (ifa.dump_valid !== 1'b0 || busy_a !== 1'b0 || done_cnt_a != dc0) begin
            failed++;
            $display("[TB] FAIL mid_reset_idle: got valid=%b busy=%b dones=%0d want 0 0 0",
                     ifa.dump_valid, busy_a, done_cnt_a - dc0);
        end
    endtask

    task test_skip_x0_off();
        int          beats, order_err, first_cyc, done_cyc;
        logic [31:0] d0;
        beats = 0; order_err = 0; first_cyc = -1; done_cyc = -1;
        d0 = 32'hFFFF_FFFF;
        ifb.dump_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wrt_en = 1'b1; wrt_dest = 5'd0; wrt_data = 32'hFFFF_FFFF;
        for (int c = 1; c <= 68; c++) begin
            tick();
            wrt_en = 1'b0;
            if (ifb.dump_valid === 1'b1) begin
                if (beats == 0) first_cyc = c;
                if (ifb.dump_addr !== 5'(beats)) order_err++;
                if (ifb.dump_addr === 5'd0) d0 = ifb.dump_data;
                beats++;
            end
            if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        tests_run++;
        if (beats != 32 || order_err != 0 || first_cyc != 1) begin
            failed++;
            $display("[TB] FAIL x0_beats: got %0d beats, %0d out of order, first %0d want 32 0 1",
                     beats, order_err, first_cyc);
        end
        tests_run++;
        if (d0 !== 32'h0000_0000) begin
            failed++;
            $display("[TB] FAIL x0_value: got %h want 00000000", d0);
        end
        tests_run++;
        if (done_cyc != 64 || busy_b !== 1'b0) begin
            failed++;
            $display("[TB] FAIL x0_done: got cycle %0d busy=%b want 64 and 0", done_cyc, busy_b);
        end
    endtask

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        wrt_en = 1'b0; wrt_dest = '0; wrt_data = '0;
        ifa.dump_ready = 1'b0;
        ifb.dump_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        test_reset();
        test_basic_dump();
        test_backpressure();
        test_write_forward();
        test_abort_restart();
        test_busy_start_and_reset();
        test_skip_x0_off();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
